// File: rtl/median_partition_stage.sv
// median_partition_stage
// One quickselect iteration of a streaming median filter. A window's control
// tokens (pivot, size, median rank, found flag) are read from one FWFT FIFO
// and its pixels from another. The pixels are split three ways around the
// pivot: smaller ones go into a "lower" buffer, larger ones into a "larger"
// buffer, and equal ones are only counted. The partition that holds the
// median is then emitted with a new pivot, size and rank. If the median is
// already known, a single value is emitted with found = 1. Windows that
// arrive with found = 1 are forwarded unchanged (bypass). This lets stages
// be chained to a fixed depth.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_px / in_px_empty / in_px_rd
//                           upstream pixel FIFO (FWFT)
//   in_pivot, in_size, in_pos, in_found / in_ctrl_empty / in_ctrl_rd
//                           upstream control-token FIFO, one word per window
//   out_px / out_px_wr / out_px_full
//                           downstream pixel FIFO
//   out_pivot, out_size, out_pos, out_found / out_ctrl_wr / out_ctrl_full
//                           downstream control-token FIFO
//   err                     sticky flag: bad window size or median rank seen
module median_partition_stage #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int SIZE_W = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_px,
    input  logic              in_px_empty,
    output logic              in_px_rd,
    input  logic [DATA_W-1:0] in_pivot,
    input  logic [SIZE_W-1:0] in_size,
    input  logic [SIZE_W-1:0] in_pos,
    input  logic              in_found,
    input  logic              in_ctrl_empty,
    output logic              in_ctrl_rd,
    output logic [DATA_W-1:0] out_px,
    output logic              out_px_wr,
    input  logic              out_px_full,
    output logic [DATA_W-1:0] out_pivot,
    output logic [SIZE_W-1:0] out_size,
    output logic [SIZE_W-1:0] out_pos,
    output logic              out_found,
    output logic              out_ctrl_wr,
    input  logic              out_ctrl_full,
    output logic              err
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SIZE_W-1:0] DEPTH_S = SIZE_W'(DEPTH);
    localparam logic [SIZE_W-1:0] ONE_S   = SIZE_W'(1);

    typedef enum logic [2:0] {IDLE, FILL, DECIDE, CTRL, SEND, BYPASS} state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] pivot_reg;
    logic [SIZE_W-1:0] pos_reg, size_reg, cnt_reg;
    logic [SIZE_W-1:0] l_reg, e_reg, g_reg;
    logic [DATA_W-1:0] min_lo_reg, max_lo_reg, min_hi_reg, max_hi_reg;
    logic [DATA_W-1:0] out_pivot_reg;
    logic [SIZE_W-1:0] out_size_reg, out_pos_reg, idx_reg;
    logic              out_found_reg, sel_hi_reg, tok_sent_reg, err_reg;

    logic              px_take, ctrl_take, px_lo, px_hi;
    logic [SIZE_W-1:0] size_clamped;
    logic [1:0]        buf_we;
    logic [ADDR_W-1:0] buf_waddr [2];
    logic [ADDR_W-1:0] rd_addr;

    // Decision results, registered into the out_* tokens in DECIDE
    logic              dec_found, dec_sel_hi;
    logic [DATA_W-1:0] dec_pivot, dec_val;
    logic [SIZE_W-1:0] dec_size, dec_pos, l_plus_e;
    logic [DATA_W:0]   sum_lo, sum_hi;

    assign px_take      = in_px_rd & ~in_px_empty;
    assign ctrl_take    = in_ctrl_rd & ~in_ctrl_empty;
    assign px_lo        = in_px < pivot_reg;
    assign px_hi        = in_px > pivot_reg;
    assign size_clamped = (in_size > DEPTH_S) ? DEPTH_S : in_size;

    assign out_pivot = out_pivot_reg;
    assign out_size  = out_size_reg;
    assign out_pos   = out_pos_reg;
    assign out_found = out_found_reg;
    assign err       = err_reg;

    // Partition buffers: index 0 holds pixels below the pivot, 1 those above.
    // Both share one read address; the read is registered, so the address for
    // the next cycle's output is prepared one cycle ahead (see rd_addr).
    always_comb begin
        buf_we[0]    = (state_reg == FILL) && px_take && px_lo;
        buf_we[1]    = (state_reg == FILL) && px_take && px_hi;
        buf_waddr[0] = ADDR_W'(l_reg);
        buf_waddr[1] = ADDR_W'(g_reg);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            logic [DATA_W-1:0] mem [DEPTH];
            logic [DATA_W-1:0] rd_q;
            always_ff @(posedge clock) begin
                if (buf_we[gi]) begin
                    mem[buf_waddr[gi]] <= in_px;
                end
                rd_q <= mem[rd_addr];
            end
        end
    endgenerate

    // Look ahead: if this cycle's pixel is written, fetch the next index now.
    // In CTRL idx_reg is 0, so the first SEND word is already in the register.
    always_comb begin
        if (state_reg == SEND && out_px_wr) begin
            rd_addr = ADDR_W'(idx_reg + ONE_S);
        end else begin
            rd_addr = ADDR_W'(idx_reg);
        end
    end

    // Choose the partition that holds rank pos_reg
    always_comb begin
        sum_lo     = {1'b0, min_lo_reg} + {1'b0, max_lo_reg};
        sum_hi     = {1'b0, min_hi_reg} + {1'b0, max_hi_reg};
        l_plus_e   = l_reg + e_reg;
        dec_found  = 1'b0;
        dec_sel_hi = 1'b0;
        dec_val    = '0;
        dec_pivot  = '0;
        dec_size   = '0;
        dec_pos    = '0;
        if (size_reg == '0) begin
            dec_found = 1'b1;
        end else if (pos_reg < l_reg) begin
            if (min_lo_reg == max_lo_reg) begin
                dec_found = 1'b1;
                dec_val   = min_lo_reg;
            end else begin
                dec_pivot = sum_lo[DATA_W:1];
                dec_size  = l_reg;
                dec_pos   = pos_reg;
            end
        end else if (pos_reg < l_plus_e) begin
            dec_found = 1'b1;
            dec_val   = pivot_reg;
        end else if (min_hi_reg == max_hi_reg) begin
            dec_found = 1'b1;
            dec_val   = min_hi_reg;
        end else begin
            dec_sel_hi = 1'b1;
            dec_pivot  = sum_hi[DATA_W:1];
            dec_size   = g_reg;
            dec_pos    = pos_reg - l_plus_e;
        end
        if (dec_found) begin
            dec_pivot = dec_val;
            dec_size  = (size_reg == '0) ? '0 : ONE_S;
            dec_pos   = '0;
        end
    end

    // Next state and handshake strobes; all strobes stay low during reset
    always_comb begin
        state_next  = state_reg;
        in_ctrl_rd  = 1'b0;
        in_px_rd    = 1'b0;
        out_ctrl_wr = 1'b0;
        out_px_wr   = 1'b0;
        out_px      = '0;
        if (!reset) begin
            case (state_reg)
                IDLE: begin
                    in_ctrl_rd = ~in_ctrl_empty;
                    if (!in_ctrl_empty) begin
                        if (in_found)            state_next = BYPASS;
                        else if (in_size == '0)  state_next = DECIDE;
                        else                     state_next = FILL;
                    end
                end
                FILL: begin
                    in_px_rd = ~in_px_empty;
                    if (!in_px_empty && cnt_reg == size_reg - ONE_S) begin
                        state_next = DECIDE;
                    end
                end
                DECIDE: state_next = CTRL;
                CTRL: begin
                    out_ctrl_wr = ~out_ctrl_full;
                    if (!out_ctrl_full) begin
                        state_next = (out_size_reg != '0) ? SEND : IDLE;
                    end
                end
                SEND: begin
                    out_px_wr = ~out_px_full;
                    out_px    = out_found_reg ? out_pivot_reg
                              : (sel_hi_reg ? g_buf[1].rd_q : g_buf[0].rd_q);
                    if (!out_px_full && idx_reg == out_size_reg - ONE_S) begin
                        state_next = IDLE;
                    end
                end
                BYPASS: begin
                    // Tokens go out first; pixels only from the following cycle
                    if (!tok_sent_reg) begin
                        out_ctrl_wr = ~out_ctrl_full;
                        if (!out_ctrl_full && out_size_reg == '0) begin
                            state_next = IDLE;
                        end
                    end else begin
                        in_px_rd  = ~in_px_empty & ~out_px_full;
                        out_px_wr = ~in_px_empty & ~out_px_full;
                        out_px    = in_px;
                        if (!in_px_empty && !out_px_full &&
                            cnt_reg == out_size_reg - ONE_S) begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            pivot_reg     <= '0;
            pos_reg       <= '0;
            size_reg      <= '0;
            cnt_reg       <= '0;
            l_reg         <= '0;
            e_reg         <= '0;
            g_reg         <= '0;
            min_lo_reg    <= '1;
            max_lo_reg    <= '0;
            min_hi_reg    <= '1;
            max_hi_reg    <= '0;
            out_pivot_reg <= '0;
            out_size_reg  <= '0;
            out_pos_reg   <= '0;
            out_found_reg <= 1'b0;
            sel_hi_reg    <= 1'b0;
            idx_reg       <= '0;
            tok_sent_reg  <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (ctrl_take) begin
                        pivot_reg    <= in_pivot;
                        pos_reg      <= in_pos;
                        size_reg     <= size_clamped;
                        cnt_reg      <= '0;
                        l_reg        <= '0;
                        e_reg        <= '0;
                        g_reg        <= '0;
                        min_lo_reg   <= '1;
                        max_lo_reg   <= '0;
                        min_hi_reg   <= '1;
                        max_hi_reg   <= '0;
                        tok_sent_reg <= 1'b0;
                        if (in_size > DEPTH_S ||
                            (in_pos >= in_size && in_size != '0)) begin
                            err_reg <= 1'b1;
                        end
                        // Bypass forwards the raw tokens, size unclamped
                        if (in_found) begin
                            out_pivot_reg <= in_pivot;
                            out_size_reg  <= in_size;
                            out_pos_reg   <= in_pos;
                            out_found_reg <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (px_take) begin
                        cnt_reg <= cnt_reg + ONE_S;
                        if (px_lo) begin
                            l_reg <= l_reg + ONE_S;
                            if (in_px < min_lo_reg) min_lo_reg <= in_px;
                            if (in_px > max_lo_reg) max_lo_reg <= in_px;
                        end else if (px_hi) begin
                            g_reg <= g_reg + ONE_S;
                            if (in_px < min_hi_reg) min_hi_reg <= in_px;
                            if (in_px > max_hi_reg) max_hi_reg <= in_px;
                        end else begin
                            e_reg <= e_reg + ONE_S;
                        end
                    end
                end
                DECIDE: begin
                    out_pivot_reg <= dec_pivot;
                    out_size_reg  <= dec_size;
                    out_pos_reg   <= dec_pos;
                    out_found_reg <= dec_found;
                    sel_hi_reg    <= dec_sel_hi;
                    idx_reg       <= '0;
                end
                SEND: begin
                    if (out_px_wr) idx_reg <= idx_reg + ONE_S;
                end
                BYPASS: begin
                    if (out_ctrl_wr) tok_sent_reg <= 1'b1;
                    if (px_take)     cnt_reg <= cnt_reg + ONE_S;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_median_partition_stage.sv
// Self-checking bench for median_partition_stage (DATA_W 8, DEPTH 16, SIZE_W 5).
// Windows come from a table of token/pixel records with hand-computed
// results. FIFO models feed and drain the DUT and can stall at random.
// Hand-written sequences cover reset state, reset in mid-window and
// the oversize-window clamp with the sticky error flag.
module tb_median_partition_stage;

    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int SW = 5;
    localparam int NV = 13;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] in_px;
    logic          in_px_empty;
    logic          in_px_rd;
    logic [DW-1:0] in_pivot;
    logic [SW-1:0] in_size;
    logic [SW-1:0] in_pos;
    logic          in_found;
    logic          in_ctrl_empty;
    logic          in_ctrl_rd;
    logic [DW-1:0] out_px;
    logic          out_px_wr;
    logic          out_px_full;
    logic [DW-1:0] out_pivot;
    logic [SW-1:0] out_size;
    logic [SW-1:0] out_pos;
    logic          out_found;
    logic          out_ctrl_wr;
    logic          out_ctrl_full;
    logic          err;

    always #5 clock = ~clock;

    median_partition_stage #(.DATA_W(DW), .DEPTH(DEPTH), .SIZE_W(SW)) dut (
        .clock(clock), .reset(reset),
        .in_px(in_px), .in_px_empty(in_px_empty), .in_px_rd(in_px_rd),
        .in_pivot(in_pivot), .in_size(in_size), .in_pos(in_pos),
        .in_found(in_found), .in_ctrl_empty(in_ctrl_empty), .in_ctrl_rd(in_ctrl_rd),
        .out_px(out_px), .out_px_wr(out_px_wr), .out_px_full(out_px_full),
        .out_pivot(out_pivot), .out_size(out_size), .out_pos(out_pos),
        .out_found(out_found), .out_ctrl_wr(out_ctrl_wr),
        .out_ctrl_full(out_ctrl_full), .err(err)
    );

    typedef struct {
        int pivot;
        int size;
        int pos;
        int found;
    } tok_t;

    typedef struct {
        tok_t in_tok;
        int   stall;
        tok_t exp_tok;
    } vec_t;

    vec_t vecs [NV];
    int   vec_px  [NV][$];
    int   vec_exp [NV][$];

    tok_t ctrl_q[$];
    tok_t got_ctrl[$];
    int   px_q[$];
    int   got_px[$];

    int   n_tests = 0;
    int   n_fail = 0;
    int   viol = 0;
    int   order_viol = 0;
    bit   stall_en = 1'b0;
    bit   px_take = 1'b0;
    bit   ctrl_take = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Upstream/downstream FIFO models: inputs change 1 time unit after the edge
    initial begin
        reset         = 1'b1;
        in_px         = '0;
        in_px_empty   = 1'b1;
        in_pivot      = '0;
        in_size       = '0;
        in_pos        = '0;
        in_found      = 1'b0;
        in_ctrl_empty = 1'b1;
        out_px_full   = 1'b0;
        out_ctrl_full = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (px_take && px_q.size() > 0) void'(px_q.pop_front());
            if (ctrl_take && ctrl_q.size() > 0) void'(ctrl_q.pop_front());
            in_px_empty   = (px_q.size() == 0) || (stall_en && $urandom_range(0, 2) == 0);
            in_px         = (px_q.size() > 0) ? DW'(px_q[0]) : '0;
            in_ctrl_empty = (ctrl_q.size() == 0) || (stall_en && $urandom_range(0, 2) == 0);
            if (ctrl_q.size() > 0) begin
                in_pivot = DW'(ctrl_q[0].pivot);
                in_size  = SW'(ctrl_q[0].size);
                in_pos   = SW'(ctrl_q[0].pos);
                in_found = ctrl_q[0].found[0];
            end
            out_px_full   = stall_en && ($urandom_range(0, 2) == 0);
            out_ctrl_full = stall_en && ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor on the falling edge: record handshakes that complete at the next rising edge
    initial begin
        tok_t t;
        forever begin
            @(negedge clock);
            px_take   = in_px_rd && !in_px_empty;
            ctrl_take = in_ctrl_rd && !in_ctrl_empty;
            if (!reset) begin
                if (in_px_rd && in_px_empty)     viol++;
                if (in_ctrl_rd && in_ctrl_empty) viol++;
                if (out_px_wr && out_px_full)    viol++;
                if (out_ctrl_wr && out_ctrl_full) viol++;
                if (out_ctrl_wr && !out_ctrl_full) begin
                    t.pivot = int'(out_pivot);
                    t.size  = int'(out_size);
                    t.pos   = int'(out_pos);
                    t.found = int'(out_found);
                    got_ctrl.push_back(t);
                end
                if (out_px_wr && !out_px_full) begin
                    if (got_ctrl.size() == 0) order_viol++;
                    got_px.push_back(int'(out_px));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_vec(input int i);
        bit done;
        int n;
        stall_en = vecs[i].stall[0];
        got_ctrl.delete();
        got_px.delete();
        ctrl_q.push_back(vecs[i].in_tok);
        foreach (vec_px[i][k]) px_q.push_back(vec_px[i][k]);
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clock);
            done = (got_ctrl.size() >= 1) && (got_px.size() >= vec_exp[i].size())
                   && (ctrl_q.size() == 0) && (px_q.size() == 0);
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL vec%0d_timeout: got %0d ctrl / %0d px, expected 1 / %0d",
                     i, got_ctrl.size(), got_px.size(), vec_exp[i].size());
        end
        stall_en = 1'b0;
        repeat (10) @(negedge clock);
        chk($sformatf("vec%0d_ctrl_count", i), got_ctrl.size(), 1);
        if (got_ctrl.size() > 0) begin
            chk($sformatf("vec%0d_pivot", i), got_ctrl[0].pivot, vecs[i].exp_tok.pivot);
            chk($sformatf("vec%0d_size", i),  got_ctrl[0].size,  vecs[i].exp_tok.size);
            chk($sformatf("vec%0d_pos", i),   got_ctrl[0].pos,   vecs[i].exp_tok.pos);
            chk($sformatf("vec%0d_found", i), got_ctrl[0].found, vecs[i].exp_tok.found);
            $display("[TB] vec %0d: ctrl pivot=%0d size=%0d pos=%0d found=%0d, %0d px",
                     i, got_ctrl[0].pivot, got_ctrl[0].size, got_ctrl[0].pos,
                     got_ctrl[0].found, got_px.size());
        end
        chk($sformatf("vec%0d_px_count", i), got_px.size(), vec_exp[i].size());
        n = (got_px.size() < vec_exp[i].size()) ? got_px.size() : vec_exp[i].size();
        for (int k = 0; k < n; k++) begin
            chk($sformatf("vec%0d_px%0d", i, k), got_px[k], vec_exp[i][k]);
        end
    endtask

    initial begin
        // ---------------- vector table ----------------
        // {pivot,size,pos,found}, stall, expected {pivot,size,pos,found}
        vecs[0]  = '{'{5, 5, 2, 0},    0, '{5, 1, 0, 1}};   // median equals pivot
        vecs[1]  = '{'{25, 6, 4, 0},   0, '{45, 4, 2, 0}};  // larger partition
        vecs[2]  = '{'{9, 4, 1, 0},    0, '{5, 4, 1, 0}};   // lower, min 2 max 8
        vecs[3]  = '{'{9, 4, 1, 0},    0, '{8, 1, 0, 1}};   // lower, min == max
        vecs[4]  = '{'{42, 1, 0, 1},   0, '{42, 1, 0, 1}};  // bypass
        vecs[5]  = '{'{7, 0, 0, 0},    0, '{0, 0, 0, 1}};   // empty window
        vecs[6]  = '{'{20, 16, 10, 0}, 0, '{31, 6, 0, 0}};  // 16 px, no stalls
        vecs[7]  = '{'{20, 16, 10, 0}, 1, '{31, 6, 0, 0}};  // same, random stalls
        vecs[8]  = '{'{4, 5, 3, 0},    0, '{4, 1, 0, 1}};   // rank inside E run
        vecs[9]  = '{'{5, 3, 2, 0},    0, '{9, 1, 0, 1}};   // larger, min == max
        vecs[10] = '{'{11, 3, 2, 1},   1, '{11, 3, 2, 1}};  // bypass with stalls
        vecs[11] = '{'{200, 5, 0, 0},  1, '{30, 3, 0, 0}};  // lower, with stalls
        vecs[12] = '{'{100, 17, 3, 0}, 0, '{7, 16, 3, 0}};  // oversize, clamped
        vec_px[0]  = '{3, 9, 1, 7, 5};            vec_exp[0]  = '{5};
        vec_px[1]  = '{10, 20, 30, 40, 50, 60};   vec_exp[1]  = '{30, 40, 50, 60};
        vec_px[2]  = '{8, 8, 8, 2};               vec_exp[2]  = '{8, 8, 8, 2};
        vec_px[3]  = '{8, 8, 8, 9};               vec_exp[3]  = '{8};
        vec_px[4]  = '{42};                       vec_exp[4]  = '{42};
        vec_px[6]  = '{12, 5, 33, 7, 19, 2, 40, 25, 8, 30, 15, 1, 22, 9, 27, 18};
        vec_exp[6] = '{33, 40, 25, 30, 22, 27};
        vec_px[7]  = vec_px[6];                   vec_exp[7]  = vec_exp[6];
        vec_px[8]  = '{4, 4, 4, 1, 6};            vec_exp[8]  = '{4};
        vec_px[9]  = '{1, 9, 9};                  vec_exp[9]  = '{9};
        vec_px[10] = '{5, 6, 7};                  vec_exp[10] = '{5, 6, 7};
        vec_px[11] = '{50, 10, 250, 30, 200};     vec_exp[11] = '{50, 10, 30};
        for (int k = 0; k < DEPTH; k++) begin
            vec_px[12].push_back(k);
            vec_exp[12].push_back(k);
        end

        // ---------------- reset state ----------------
        reset = 1'b1;
        ctrl_q.push_back('{1, 1, 0, 0});
        repeat (3) @(negedge clock);
        chk("rst_ctrl_rd", int'(in_ctrl_rd), 0);
        chk("rst_px_rd", int'(in_px_rd), 0);
        chk("rst_ctrl_wr", int'(out_ctrl_wr), 0);
        chk("rst_px_wr", int'(out_px_wr), 0);
        chk("rst_err", int'(err), 0);
        ctrl_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_out_pivot", int'(out_pivot), 0);
        chk("rst_out_size", int'(out_size), 0);
        chk("rst_out_pos", int'(out_pos), 0);
        chk("rst_out_found", int'(out_found), 0);
        chk("rst_out_px", int'(out_px), 0);
        chk("rst_no_writes", got_ctrl.size() + got_px.size(), 0);

        // ---------------- table-driven windows ----------------
        for (int i = 0; i < NV - 1; i++) run_vec(i);

        // ---------------- reset in the middle of FILL ----------------
        got_ctrl.delete();
        got_px.delete();
        ctrl_q.push_back('{5, 8, 0, 0});
        px_q.push_back(1);
        px_q.push_back(2);
        px_q.push_back(3);
        repeat (10) @(negedge clock);
        chk("midfill_px_consumed", px_q.size(), 0);
        reset = 1'b1;
        px_q.delete();
        ctrl_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("midfill_no_ctrl_out", got_ctrl.size(), 0);
        chk("midfill_no_px_out", got_px.size(), 0);
        $display("[TB] reset during FILL: window abandoned");
        run_vec(0);

        // ---------------- oversize window: clamp and sticky error ----------------
        chk("err_before_oversize", int'(err), 0);
        run_vec(NV - 1);
        chk("err_after_oversize", int'(err), 1);
        repeat (3) @(negedge clock);
        chk("err_sticky", int'(err), 1);

        chk("handshake_violations", viol, 0);
        chk("px_before_tokens", order_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
